// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - round-robin 4-way arbiter driving a registered mux select
module rr_mux_sel_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit               TIMER_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = TIMER_EN ? CNT_W'(HOLD_MAX) : {CNT_W{1'b1}};

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       timer_hit;
    logic       owner_req;
    logic       release_now;

    // Search starts just after the last-granted index so the previous owner ranks lowest.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + i[1:0];
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req   = req[sel];
        timer_hit   = TIMER_EN && (cnt == CNT_LAST);
        release_now = done || !owner_req || timer_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            cnt       <= '0;
            sel       <= 2'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel       <= winner;
                        gnt       <= 4'b0001 << winner;
                        gnt_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        ptr       <= sel;
                        // Only a pure timer revocation is flagged; done or a dropped request win.
                        timeout   <= !done && owner_req && timer_hit;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
